// File: rtl/apb_uart_rx_if.sv
// Byte delivery channel from the UART receiver to the APB register/FIFO side.
// rx_valid_o holds until rx_valid_o & rx_ready_i; rx_data_o is stable meanwhile.
interface apb_uart_rx_if;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       rx_ready_i;

  modport slave  (output rx_data_o, output rx_valid_o, input  rx_ready_i);
  modport master (input  rx_data_o, input  rx_valid_o, output rx_ready_i);
endinterface

// File: rtl/apb_uart_rx.sv
// UART receiver: synchronises rx_i, samples mid-bit with a programmable divider,
// delivers 5-8 bit bytes on a valid/ready channel and keeps sticky error flags.
module apb_uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_en_i,
  input  logic [15:0] cfg_div_i,
  input  logic        cfg_parity_en_i,
  input  logic [1:0]  cfg_bits_i,
  input  logic        cfg_stop_bits_i,
  input  logic        rx_i,
  apb_uart_rx_if.slave rx_if,
  output logic        err_parity_o,
  output logic        err_frame_o,
  output logic        err_overrun_o,
  input  logic        err_clr_i,
  output logic        busy_o,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    PARITY     = 3'd3,
    STOP_FIRST = 3'd4,
    STOP_LAST  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s, rx_q;
  logic [15:0]            baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   complete;
  logic [2:0]             last_bit;
  logic                   half_hit, full_hit;

  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   errp_q, errp_d;
  logic                   errf_q, errf_d;
  logic                   erro_q, erro_d;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign last_bit = 3'd4 + {1'b0, cfg_bits_i};
  assign half_hit = (baud_q == (cfg_div_i >> 1));
  assign full_hit = (baud_q == cfg_div_i);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      rx_q    <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      errp_q  <= 1'b0;
      errf_q  <= 1'b0;
      erro_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], rx_i};
      rx_q    <= rx_s;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      errp_q  <= errp_d;
      errf_q  <= errf_d;
      erro_q  <= erro_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_d    = par_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    complete = 1'b0;
    if (state_q != IDLE) baud_d = baud_q + 16'd1;
    case (state_q)
      IDLE: begin
        // Only a high-to-low transition starts a frame, so a held-low line is ignored.
        if (cfg_en_i && rx_q && !rx_s) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (half_hit) begin
          baud_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = '0;
            par_d   = 1'b0;
            shift_d = '0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (full_hit) begin
          baud_d         = '0;
          shift_d[bit_q] = rx_s;
          par_d          = par_q ^ rx_s;
          if (bit_q == last_bit) state_d = cfg_parity_en_i ? PARITY : STOP_FIRST;
          else                   bit_d   = bit_q + 3'd1;
        end
      end
      PARITY: begin
        if (full_hit) begin
          baud_d  = '0;
          perr_d  = (rx_s != par_q);
          state_d = STOP_FIRST;
        end
      end
      STOP_FIRST: begin
        if (full_hit) begin
          baud_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (cfg_stop_bits_i) begin
            state_d = STOP_LAST;
          end else begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
      end
      STOP_LAST: begin
        if (full_hit) begin
          baud_d   = '0;
          if (!rx_s) ferr_d = 1'b1;
          state_d  = IDLE;
          complete = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!cfg_en_i) begin
      state_d  = IDLE;
      baud_d   = '0;
      bit_d    = '0;
      complete = 1'b0;
    end
  end

  // A completing frame may replace a byte being consumed in the same cycle.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (!cfg_en_i) begin
      valid_d = 1'b0;
    end else if (complete && (!valid_q || rx_if.rx_ready_i)) begin
      valid_d = 1'b1;
      data_d  = shift_q;
    end else if (valid_q && rx_if.rx_ready_i) begin
      valid_d = 1'b0;
    end

    errp_d = err_clr_i ? 1'b0 : errp_q;
    errf_d = err_clr_i ? 1'b0 : errf_q;
    erro_d = err_clr_i ? 1'b0 : erro_q;
    if (complete && perr_q) errp_d = 1'b1;
    if (complete && ferr_d) errf_d = 1'b1;
    if (complete && valid_q && !rx_if.rx_ready_i) erro_d = 1'b1;
  end

  assign rx_if.rx_data_o  = data_q;
  assign rx_if.rx_valid_o = valid_q;
  assign err_parity_o     = errp_q;
  assign err_frame_o      = errf_q;
  assign err_overrun_o    = erro_q;
  assign busy_o           = (state_q != IDLE);
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_apb_uart_rx.sv
// Directed bench for apb_uart_rx: serial frames are driven on rx_i, expected
// bytes are queued at issue time and checked when the consumer accepts them.
module tb_apb_uart_rx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cfg_en;
  logic [15:0] cfg_div;
  logic        cfg_parity_en;
  logic [1:0]  cfg_bits;
  logic        cfg_stop_bits;
  logic        rx_line;
  logic        err_clr;
  logic        err_parity, err_frame, err_overrun, busy;
  logic [2:0]  dbg_state;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  mon_exp;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_STOP_FIRST = 3'd4;

  apb_uart_rx_if rx_if ();

  apb_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cfg_en_i        (cfg_en),
    .cfg_div_i       (cfg_div),
    .cfg_parity_en_i (cfg_parity_en),
    .cfg_bits_i      (cfg_bits),
    .cfg_stop_bits_i (cfg_stop_bits),
    .rx_i            (rx_line),
    .rx_if           (rx_if.slave),
    .err_parity_o    (err_parity),
    .err_frame_o     (err_frame),
    .err_overrun_o   (err_overrun),
    .err_clr_i       (err_clr),
    .busy_o          (busy),
    .dbg_state_o     (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard monitor: compare every accepted byte against the expected queue
  always @(negedge clk) begin
    if (reset_n && rx_if.rx_valid_o && rx_if.rx_ready_i) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_byte: got %02h, none expected", rx_if.rx_data_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rx_if.rx_data_o !== mon_exp) begin
          n_errors++;
          $display("FAIL rx_byte: got %02h expected %02h", rx_if.rx_data_o, mon_exp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_cfg(input int div, input int nbits, input bit par, input bit stop2);
    cfg_div       = div[15:0];
    cfg_bits      = 2'(nbits - 5);
    cfg_parity_en = par;
    cfg_stop_bits = stop2;
  endtask

  task automatic hold_bit(input logic v);
    #1 rx_line = v;
    repeat (int'(cfg_div) + 1) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input bit par_flip, input bit stop_low);
    logic p;
    int   nbits;
    p     = 1'b0;
    nbits = int'(cfg_bits) + 5;
    @(posedge clk);
    hold_bit(1'b0);
    for (int i = 0; i < nbits; i++) begin
      hold_bit(data[i]);
      p = p ^ data[i];
    end
    if (cfg_parity_en) hold_bit(p ^ par_flip);
    hold_bit(!stop_low);
    if (cfg_stop_bits) hold_bit(!stop_low);
  endtask

  task automatic wait_not_busy(input string name);
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 5000 && !idle; i++) begin
      @(posedge clk);
      #1;
      if (!busy) idle = 1'b1;
    end
    check(name, {15'd0, idle}, 16'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dbg_state == st) seen = 1'b1;
    end
    check(name, {15'd0, seen}, 16'd1);
  endtask

  // returns #1 after the edge that opens the final stop sample cycle (one stop bit)
  task automatic wait_completion_cycle(input string name);
    wait_state(ST_STOP_FIRST, name);
    repeat (int'(cfg_div)) @(posedge clk);
    #1;
  endtask

  task automatic clear_errors();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    cfg_en  = 1'b1;
    rx_line = 1'b1;
    err_clr = 1'b0;
    rx_if.rx_ready_i = 1'b1;
    set_cfg(3, 8, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_data", rx_if.rx_data_o, 16'h00);
    check("reset_valid", rx_if.rx_valid_o, 0);
    check("reset_errs", {err_parity, err_frame, err_overrun}, 0);
    check("reset_busy", busy, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // 1: div=3 8N1 0xA5
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b0);
    wait_not_busy("t1_idle");
    check("t1_errs", {err_parity, err_frame, err_overrun}, 0);
    check("t1_busy", busy, 0);

    // 2: div=15, 5 bits, even parity, 2 stop: good then flipped parity
    set_cfg(15, 5, 1'b1, 1'b1);
    exp_q.push_back(8'h16);
    send_frame(8'h16, 1'b0, 1'b0);
    wait_not_busy("t2a_idle");
    check("t2a_perr", err_parity, 0);
    exp_q.push_back(8'h16);
    send_frame(8'h16, 1'b1, 1'b0);
    wait_not_busy("t2b_idle");
    check("t2b_perr", err_parity, 1);
    check("t2b_ferr", err_frame, 0);
    clear_errors();
    check("t2_clr", err_parity, 0);

    // 3: div=7 8N1 stop forced low, line stays low
    set_cfg(7, 8, 1'b0, 1'b0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1);
    repeat (60) @(posedge clk);
    #1;
    check("t3_ferr", err_frame, 1);
    check("t3_break_busy", busy, 0);
    rx_line = 1'b1;
    repeat (20) @(posedge clk);
    clear_errors();
    exp_q.push_back(8'hC3);
    send_frame(8'hC3, 1'b0, 1'b0);
    wait_not_busy("t3_idle");
    check("t3_ferr_clean", err_frame, 0);

    // 4: 2-cycle glitch at div=15
    set_cfg(15, 8, 1'b0, 1'b0);
    @(posedge clk);
    #1 rx_line = 1'b0;
    repeat (2) @(posedge clk);
    #1 rx_line = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("t4_busy", busy, 0);
    check("t4_valid", rx_if.rx_valid_o, 0);
    check("t4_errs", {err_parity, err_frame, err_overrun}, 0);

    // 5: overrun, replace-in-completion-cycle, clear vs set
    set_cfg(7, 8, 1'b0, 1'b0);
    rx_if.rx_ready_i = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b0);
    send_frame(8'h22, 1'b0, 1'b0);
    wait_not_busy("t5a_idle");
    check("t5a_data", rx_if.rx_data_o, 16'h11);
    check("t5a_valid", rx_if.rx_valid_o, 1);
    check("t5a_ovr", err_overrun, 1);
    rx_if.rx_ready_i = 1'b1;
    @(posedge clk);
    #1 rx_if.rx_ready_i = 1'b0;
    clear_errors();
    exp_q.push_back(8'h44);
    send_frame(8'h44, 1'b0, 1'b0);
    wait_not_busy("t5b_pend_idle");
    exp_q.push_back(8'h22);
    fork
      send_frame(8'h22, 1'b0, 1'b0);
      begin
        wait_completion_cycle("t5b_stop");
        rx_if.rx_ready_i = 1'b1;
        @(posedge clk);
        #1 rx_if.rx_ready_i = 1'b0;
      end
    join
    wait_not_busy("t5b_idle");
    check("t5b_data", rx_if.rx_data_o, 16'h22);
    check("t5b_valid", rx_if.rx_valid_o, 1);
    check("t5b_ovr", err_overrun, 0);
    fork
      send_frame(8'h33, 1'b0, 1'b0);
      begin
        wait_completion_cycle("t5c_stop");
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
      end
    join
    wait_not_busy("t5c_idle");
    check("t5c_ovr_set_wins", err_overrun, 1);
    check("t5c_data", rx_if.rx_data_o, 16'h22);
    rx_if.rx_ready_i = 1'b1;
    @(posedge clk);
    clear_errors();

    // 6a: enable dropped mid-DATA with a byte pending
    rx_if.rx_ready_i = 1'b0;
    send_frame(8'h5A, 1'b0, 1'b0);
    wait_not_busy("t6a_pend_idle");
    check("t6a_pend_data", rx_if.rx_data_o, 16'h5A);
    check("t6a_pend_valid", rx_if.rx_valid_o, 1);
    fork
      send_frame(8'h0F, 1'b0, 1'b0);
      begin
        wait_state(ST_DATA, "t6a_data_state");
        repeat (3) @(posedge clk);
        #1 cfg_en = 1'b0;
        @(posedge clk);
        #1;
        check("t6a_state", dbg_state, ST_IDLE);
        check("t6a_busy", busy, 0);
        check("t6a_valid", rx_if.rx_valid_o, 0);
        check("t6a_data_kept", rx_if.rx_data_o, 16'h5A);
      end
    join
    repeat (10) @(posedge clk);
    #1 cfg_en = 1'b1;
    rx_if.rx_ready_i = 1'b1;
    repeat (10) @(posedge clk);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b0);
    wait_not_busy("t6a_idle");
    check("t6a_next_data", rx_if.rx_data_o, 16'h81);

    // 6b: reset pulsed mid-frame
    fork
      send_frame(8'h99, 1'b0, 1'b0);
      begin
        wait_state(ST_DATA, "t6b_data_state");
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("t6b_busy", busy, 0);
        check("t6b_valid", rx_if.rx_valid_o, 0);
        check("t6b_data", rx_if.rx_data_o, 16'h00);
      end
    join
    @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b0, 1'b0);
    wait_not_busy("t6b_idle");
    check("t6b_next_data", rx_if.rx_data_o, 16'h42);
    check("t6b_errs", {err_parity, err_frame, err_overrun}, 0);

    // final report
    repeat (5) @(posedge clk);
    check("exp_queue_empty", 16'(exp_q.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/apb_uart_rx.md
Name: apb_uart_rx

Overview:
UART receiver paired with apb_uart_tx in the APB UART peripheral. Deserialises the rx line using the same configuration fields as the transmitter: divider, 5-8 data bits, optional even parity, 1 or 2 stop bits. Delivers bytes to the APB register/FIFO side through a valid/ready handshake. Reports sticky parity, framing and overrun errors.

Parameters:
SYNC_STAGES, 2, number of flops in the rx_i synchroniser (minimum 2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
cfg_en_i  input  1  receiver enable; low forces IDLE
cfg_div_i  input  16  bit period is cfg_div_i+1 clk cycles (matches TX)
cfg_parity_en_i  input  1  parity bit present, even parity
cfg_bits_i  input  2  00=5, 01=6, 10=7, 11=8 data bits
cfg_stop_bits_i  input  1  0=one stop bit, 1=two stop bits
rx_i  input  1  asynchronous serial input, idle high
rx_data_o  output  8  received byte, LSB first on line, unused MSBs zero-filled
rx_valid_o  output  1  rx_data_o holds an unconsumed byte
rx_ready_i  input  1  consumer accepts byte when rx_valid_o & rx_ready_i
err_parity_o  output  1  sticky parity error
err_frame_o  output  1  sticky framing error (stop bit sampled 0)
err_overrun_o  output  1  sticky overrun (frame completed while rx_valid_o pending)
err_clr_i  input  1  clears all three sticky errors
busy_o  output  1  state != IDLE

Behaviour:
- Reset values: rx_data_o=0, rx_valid_o=0, all err_*=0, busy_o=0, state IDLE, synchroniser flops=1, counters=0.
- rx_i passes through SYNC_STAGES flops (rx_s); one further flop rx_q is used for edge detection.
- States: IDLE, START, DATA, PARITY, STOP_FIRST, STOP_LAST.
- IDLE: when cfg_en_i is high and a falling edge is seen (rx_q=1, rx_s=0), go to START and clear baud_cnt. A line that is already low when the block enters IDLE does not trigger a frame (break tolerance).
- Baud counter:
  - Increments every cycle outside IDLE.
  - START samples at baud_cnt==cfg_div_i>>1 (mid-bit), then clears baud_cnt.
  - All later bits sample at baud_cnt==cfg_div_i, then clear baud_cnt. This keeps sampling mid-bit.
- START: sample 0 goes to DATA with bit_cnt=0 and parity accumulator=0. Sample 1 is a false start; return to IDLE with no output and no error.
- DATA:
  - Each sample is shifted into bit position bit_cnt and XORed into the parity accumulator.
  - After bit_cnt == target-1 (target = 5..8), go to PARITY if cfg_parity_en_i, else STOP_FIRST.
- PARITY: parity error if the sampled bit != accumulator. Go to STOP_FIRST.
- STOP_FIRST: sample 0 means framing error. Then:
  - cfg_stop_bits_i=1: go to STOP_LAST.
  - cfg_stop_bits_i=0: complete the frame and go to IDLE.
- STOP_LAST: sample 0 means framing error. Complete the frame and go to IDLE.
- Frame completion, registered on the cycle after the final stop sample:
  - If rx_valid_o is low, or rx_ready_i is high in the completion cycle: load rx_data_o and set rx_valid_o=1.
  - Otherwise: keep the old byte, discard the new one, set err_overrun_o.
  - A byte with a parity or framing error is still delivered; its error flag sets in the same cycle rx_valid_o rises.
- Handshake: rx_valid_o stays high and rx_data_o stays stable until rx_valid_o & rx_ready_i. It clears the next cycle unless a new frame completes in that same cycle. rx_ready_i while rx_valid_o=0 is ignored.
- Sticky errors: err_clr_i clears them. If a set event and err_clr_i occur in the same cycle, set wins.
- cfg_en_i low:
  - State goes to IDLE next cycle; baud_cnt, bit_cnt and the partial byte are discarded.
  - rx_valid_o clears.
  - Sticky errors and rx_data_o are retained.
- Config fields are sampled live and must be held stable while busy_o=1; changing them mid-frame gives an undefined frame but the FSM must still return to IDLE.
- Reset asserted mid-frame: immediate return to reset values, no partial output.
- Latency, falling edge at rx_i to rx_valid_o: SYNC_STAGES + (cfg_div_i>>1) + (N_bits-1)*(cfg_div_i+1) + ~3 cycles, where N_bits includes start, data, parity and stop bits.

Test Plan:
1. div=3, 8N1, drive 0xA5 from apb_uart_tx in loopback -> rx_valid_o=1 with rx_data_o=8'hA5; no errors; busy_o low afterwards.
2. div=15, 5 bits, even parity, 2 stop, send 5'b10110 -> rx_data_o=8'h16; then send the same frame with the parity bit flipped -> byte 8'h16 delivered and err_parity_o=1.
3. div=7, 8N1, stop bit forced 0 -> err_frame_o=1, byte delivered; line held low afterwards -> no new frame until the line returns high and falls again.
4. Glitch low for 2 cycles (div=15) -> false start; no rx_valid_o, no error, busy_o back to 0.
5. Two back-to-back frames 0x11 and 0x22 with rx_ready_i=0 -> rx_data_o stays 8'h11 and err_overrun_o=1. Repeat with rx_ready_i=1 in the completion cycle -> 8'h22 loaded, no overrun. Then err_clr_i together with a new error event -> flag stays 1.
6. Deassert cfg_en_i in mid-DATA, and separately pulse reset_n low mid-frame -> IDLE next cycle (or immediately for reset), rx_valid_o=0, no spurious byte; the next full frame is received correctly.
